// File: rtl/victim_fill_ctrl.sv
// Miss handler for an 8-way set: picks a victim way, issues one refill request,
// then writes the way and updates the LRU stack (or reports an error on a failed refill).
module victim_fill_ctrl #(
  parameter int unsigned TAG_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_miss_req,
  input  logic [TAG_W-1:0] i_miss_tag,
  input  logic [7:0]       i_way_valid_8,
  input  logic [2:0]       i_lru_order0,
  input  logic [2:0]       i_lru_order1,
  input  logic [2:0]       i_lru_order2,
  input  logic [2:0]       i_lru_order3,
  input  logic [2:0]       i_lru_order4,
  input  logic [2:0]       i_lru_order5,
  input  logic [2:0]       i_lru_order6,
  output logic             o_mem_req_valid,
  input  logic             i_mem_req_ready,
  output logic [TAG_W-1:0] o_mem_req_tag,
  input  logic             i_mem_rsp_valid,
  input  logic             i_mem_rsp_err,
  output logic             o_fill_we,
  output logic [7:0]       o_fill_way_8,
  output logic [TAG_W-1:0] o_fill_tag,
  output logic [7:0]       o_hit_way_8,
  output logic             o_hit_sig,
  output logic             o_lru_write_enable,
  output logic             o_miss_ack,
  output logic             o_miss_err,
  output logic             o_busy,
  output logic [2:0]       o_victim_way
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_FILL   = 3'd3,
    S_UPDATE = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic [TAG_W-1:0] r_tag;
  logic [2:0]       r_victim;
  logic [2:0]       w_victim;
  logic [7:0]       w_victim_oh;

  // Lowest invalid way wins; with all ways valid the LRU way is the one missing from the stack.
  always_comb begin
    w_victim = i_lru_order0 ^ i_lru_order1 ^ i_lru_order2 ^ i_lru_order3 ^
               i_lru_order4 ^ i_lru_order5 ^ i_lru_order6;
    for (int i = 7; i >= 0; i--) begin
      if (!i_way_valid_8[i]) w_victim = 3'(i);
    end
  end

  // FILL/UPDATE are never entered straight from IDLE, so the latched victim is always current.
  assign w_victim_oh = 8'(1) << r_victim;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_miss_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ:    if (i_mem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_mem_rsp_valid) w_state_nxt = i_mem_rsp_err ? S_ABORT : S_FILL;
      end
      S_FILL:   w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      S_ABORT:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tag    <= '0;
      r_victim <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tag    <= i_miss_tag;
        r_victim <= w_victim;
      end
    end
  end

  // Strobes are registered from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mem_req_valid    <= 1'b0;
      o_fill_we          <= 1'b0;
      o_fill_way_8       <= 8'h00;
      o_hit_way_8        <= 8'h00;
      o_hit_sig          <= 1'b0;
      o_lru_write_enable <= 1'b0;
      o_miss_ack         <= 1'b0;
      o_miss_err         <= 1'b0;
      o_busy             <= 1'b0;
    end else begin
      o_mem_req_valid    <= (w_state_nxt == S_REQ);
      o_fill_we          <= (w_state_nxt == S_FILL);
      o_fill_way_8       <= (w_state_nxt == S_FILL) ? w_victim_oh : 8'h00;
      o_hit_way_8        <= (w_state_nxt == S_UPDATE) ? w_victim_oh : 8'h00;
      o_hit_sig          <= (w_state_nxt == S_UPDATE);
      o_lru_write_enable <= (w_state_nxt == S_UPDATE);
      o_miss_ack         <= (w_state_nxt == S_UPDATE) || (w_state_nxt == S_ABORT);
      o_miss_err         <= (w_state_nxt == S_ABORT);
      o_busy             <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_mem_req_tag = r_tag;
  assign o_fill_tag    = r_tag;
  assign o_victim_way  = r_victim;

endmodule

// File: tb/tb_victim_fill_ctrl.sv
// Bench for victim_fill_ctrl: transaction-level model checked every cycle, plus directed literal checks.
module tb_victim_fill_ctrl;
  localparam int unsigned TAG_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_miss_req;
  logic [TAG_W-1:0] i_miss_tag;
  logic [7:0]       i_way_valid_8;
  logic [2:0]       i_lru_order0, i_lru_order1, i_lru_order2, i_lru_order3;
  logic [2:0]       i_lru_order4, i_lru_order5, i_lru_order6;
  logic             o_mem_req_valid;
  logic             i_mem_req_ready;
  logic [TAG_W-1:0] o_mem_req_tag;
  logic             i_mem_rsp_valid;
  logic             i_mem_rsp_err;
  logic             o_fill_we;
  logic [7:0]       o_fill_way_8;
  logic [TAG_W-1:0] o_fill_tag;
  logic [7:0]       o_hit_way_8;
  logic             o_hit_sig;
  logic             o_lru_write_enable;
  logic             o_miss_ack;
  logic             o_miss_err;
  logic             o_busy;
  logic [2:0]       o_victim_way;

  always #5 clk = ~clk;

  victim_fill_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_tag(i_miss_tag), .i_way_valid_8(i_way_valid_8),
    .i_lru_order0(i_lru_order0), .i_lru_order1(i_lru_order1), .i_lru_order2(i_lru_order2),
    .i_lru_order3(i_lru_order3), .i_lru_order4(i_lru_order4), .i_lru_order5(i_lru_order5),
    .i_lru_order6(i_lru_order6),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_tag(o_mem_req_tag),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_err(i_mem_rsp_err),
    .o_fill_we(o_fill_we), .o_fill_way_8(o_fill_way_8), .o_fill_tag(o_fill_tag),
    .o_hit_way_8(o_hit_way_8), .o_hit_sig(o_hit_sig), .o_lru_write_enable(o_lru_write_enable),
    .o_miss_ack(o_miss_ack), .o_miss_err(o_miss_err), .o_busy(o_busy),
    .o_victim_way(o_victim_way)
  );

  int n_vec = 0;
  int n_err = 0;
  bit m_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a transaction is request-outstanding, then response-awaited, then a short
  // queue of post-response cycles (1 = write the way, 2 = LRU update + ack, 3 = error ack).
  logic [TAG_W-1:0] m_tag;
  logic [2:0]       m_victim;
  bit               m_req, m_wait;
  int               m_q[$];
  int               m_cur;
  logic [20:0]      w_ord;

  assign w_ord = {i_lru_order6, i_lru_order5, i_lru_order4, i_lru_order3,
                  i_lru_order2, i_lru_order1, i_lru_order0};

  function automatic logic [2:0] f_victim(input logic [7:0] vld, input logic [20:0] ord);
    bit seen;
    for (int w = 0; w < 8; w++) if (!vld[w]) return 3'(w);
    for (int w = 0; w < 8; w++) begin
      seen = 1'b0;
      for (int j = 0; j < 7; j++) if (ord[3*j +: 3] == 3'(w)) seen = 1'b1;
      if (!seen) return 3'(w);
    end
    return 3'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tag = '0; m_victim = 3'd0; m_req = 1'b0; m_wait = 1'b0; m_q.delete();
    end else if (m_q.size() > 0) begin
      void'(m_q.pop_front());
    end else if (m_req) begin
      if (i_mem_req_ready) begin m_req = 1'b0; m_wait = 1'b1; end
    end else if (m_wait) begin
      if (i_mem_rsp_valid) begin
        m_wait = 1'b0;
        if (i_mem_rsp_err) m_q.push_back(3);
        else begin m_q.push_back(1); m_q.push_back(2); end
      end
    end else if (i_miss_req) begin
      m_tag = i_miss_tag; m_victim = f_victim(i_way_valid_8, w_ord); m_req = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_on) begin
      m_cur = (m_q.size() > 0) ? m_q[0] : 0;
      chk("req_valid", 32'(o_mem_req_valid), 32'(m_req));
      chk("req_tag",   32'(o_mem_req_tag), 32'(m_tag));
      chk("fill_we",   32'(o_fill_we), 32'(m_cur == 1));
      chk("fill_way",  32'(o_fill_way_8), (m_cur == 1) ? 32'(1) << m_victim : 32'd0);
      chk("fill_tag",  32'(o_fill_tag), 32'(m_tag));
      chk("hit_way",   32'(o_hit_way_8), (m_cur == 2) ? 32'(1) << m_victim : 32'd0);
      chk("hit_sig",   32'(o_hit_sig), 32'(m_cur == 2));
      chk("lru_we",    32'(o_lru_write_enable), 32'(m_cur == 2));
      chk("miss_ack",  32'(o_miss_ack), 32'(m_cur == 2 || m_cur == 3));
      chk("miss_err",  32'(o_miss_err), 32'(m_cur == 3));
      chk("busy",      32'(o_busy), 32'(m_req || m_wait || m_cur != 0));
      chk("victim",    32'(o_victim_way), 32'(m_victim));
    end
  end

  task automatic set_ord(input logic [20:0] ord);
    {i_lru_order6, i_lru_order5, i_lru_order4, i_lru_order3,
     i_lru_order2, i_lru_order1, i_lru_order0} = ord;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},  32'(o_busy), 32'd0);
    chk({nm, "_reqv"},  32'(o_mem_req_valid), 32'd0);
    chk({nm, "_reqt"},  32'(o_mem_req_tag), 32'd0);
    chk({nm, "_fill"},  32'({o_fill_we, o_fill_way_8}), 32'd0);
    chk({nm, "_ftag"},  32'(o_fill_tag), 32'd0);
    chk({nm, "_lru"},   32'({o_hit_sig, o_lru_write_enable, o_hit_way_8}), 32'd0);
    chk({nm, "_ack"},   32'({o_miss_ack, o_miss_err}), 32'd0);
    chk({nm, "_vict"},  32'(o_victim_way), 32'd0);
  endtask

  // Per-miss observations, relative to the accepting cycle (cycle 0).
  int   t_req_first, t_req_cnt, t_hs, t_fill_cyc, t_ack_cyc, t_fill_cnt, t_lru_cnt;
  bit   t_tag_bad, t_err, t_busy0;
  logic [7:0] t_fill_way, t_hit_way;

  task automatic do_miss(input logic [TAG_W-1:0] tag, input logic [7:0] vld,
                         input logic [20:0] ord, input int rdy_wait, input int rsp_off,
                         input logic err, input logic junk, input logic hold);
    int cyc;
    int rsp_cyc;
    bit done;
    t_req_first = -1; t_req_cnt = 0; t_hs = 0; t_fill_cyc = -1; t_ack_cyc = -1;
    t_fill_cnt = 0; t_lru_cnt = 0; t_tag_bad = 1'b0; t_err = 1'b0;
    t_fill_way = 8'h00; t_hit_way = 8'h00;
    rsp_cyc = 2 + rdy_wait + rsp_off;
    @(negedge clk);
    t_busy0 = o_busy;
    i_miss_req = 1'b1; i_miss_tag = tag; i_way_valid_8 = vld; set_ord(ord);
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_mem_req_valid) begin
        if (t_req_first < 0) t_req_first = cyc;
        t_req_cnt++;
        if (o_mem_req_tag !== tag) t_tag_bad = 1'b1;
      end
      if (o_fill_we) begin t_fill_cnt++; t_fill_cyc = cyc; t_fill_way = o_fill_way_8; end
      if (o_lru_write_enable) t_lru_cnt++;
      if (o_miss_ack) begin
        t_ack_cyc = cyc; t_hit_way = o_hit_way_8; t_err = o_miss_err; done = 1'b1;
        if (!hold) i_miss_req = 1'b0;
      end
      // Disturb the sampled inputs after acceptance; they must not affect this miss.
      i_miss_tag = ~tag; i_way_valid_8 = 8'h00; set_ord(~ord);
      i_mem_req_ready = (cyc > rdy_wait);
      i_mem_rsp_valid = (cyc == rsp_cyc) || (junk && cyc == 1);
      i_mem_rsp_err   = err && (cyc == rsp_cyc);
      if (o_mem_req_valid && i_mem_req_ready) t_hs++;
    end
    if (!done) begin
      chk("ack_timeout", 32'd0, 32'd1);
      i_miss_req = 1'b0;
    end
  endtask

  localparam logic [20:0] ORD_UP = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [20:0] ORD_DN = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

  initial begin
    rst = 1'b1;
    i_miss_req = 1'b0; i_miss_tag = '0; i_way_valid_8 = 8'hff; set_ord(ORD_UP);
    i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    m_on = 1'b1;
    chk_zero("reset");
    rst = 1'b0;

    // Nominal miss, all ways valid, LRU way 7.
    do_miss(20'h12345, 8'hff, ORD_UP, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("n_first_req", 32'(t_req_first), 32'd1);
    chk("n_req_tag",   32'(t_tag_bad), 32'd0);
    chk("n_victim",    32'(o_victim_way), 32'd7);
    chk("n_fill_cyc",  32'(t_fill_cyc), 32'd4);
    chk("n_fill_way",  32'(t_fill_way), 32'h80);
    chk("n_ack_cyc",   32'(t_ack_cyc), 32'd5);
    chk("n_hit_way",   32'(t_hit_way), 32'h80);
    @(negedge clk);
    chk("n_idle", 32'(o_busy), 32'd0);

    // Reversed stack -> way 0; then way 3 invalid overrides the LRU choice.
    do_miss(20'h0abcd, 8'hff, ORD_DN, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("rev_victim",   32'(o_victim_way), 32'd0);
    chk("rev_fill_way", 32'(t_fill_way), 32'h01);
    do_miss(20'h55555, 8'b1111_0111, ORD_DN, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("inv_victim",   32'(o_victim_way), 32'd3);
    chk("inv_fill_way", 32'(t_fill_way), 32'h08);
    chk("inv_hit_way",  32'(t_hit_way), 32'h08);
    do_miss(20'hf0f0f, 8'b0010_1011, ORD_UP, 2, 3, 1'b0, 1'b0, 1'b0);
    chk("inv2_victim",  32'(o_victim_way), 32'd2);
    chk("inv2_ack_cyc", 32'(t_ack_cyc), 32'd9);

    // Backpressure for 5 cycles with a stray response pulse while requesting.
    do_miss(20'h9e3c1, 8'hff, ORD_UP, 5, 0, 1'b0, 1'b1, 1'b0);
    chk("bp_req_cnt",  32'(t_req_cnt), 32'd6);
    chk("bp_req_tag",  32'(t_tag_bad), 32'd0);
    chk("bp_hs",       32'(t_hs), 32'd1);
    chk("bp_fill_cyc", 32'(t_fill_cyc), 32'd8);
    chk("bp_ack_cyc",  32'(t_ack_cyc), 32'd9);

    // Error response: single error ack, no fill, no LRU update.
    do_miss(20'h00777, 8'hff, ORD_DN, 0, 2, 1'b1, 1'b0, 1'b0);
    chk("err_ack_cyc", 32'(t_ack_cyc), 32'd5);
    chk("err_flag",    32'(t_err), 32'd1);
    chk("err_fill",    32'(t_fill_cnt), 32'd0);
    chk("err_lru",     32'(t_lru_cnt), 32'd0);
    chk("err_hit_way", 32'(t_hit_way), 32'h00);
    @(negedge clk);
    chk("err_idle", 32'(o_busy), 32'd0);

    // Asynchronous reset while waiting for the response.
    @(negedge clk);
    i_miss_req = 1'b1; i_miss_tag = 20'h3c3c3; i_way_valid_8 = 8'hff; set_ord(ORD_UP);
    i_mem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rw_in_wait", 32'({o_busy, o_mem_req_valid}), 32'b10);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    i_miss_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    i_mem_rsp_valid = 1'b1;
    @(negedge clk);
    i_mem_rsp_valid = 1'b0;
    chk("rst_rsp_ignored", 32'({o_busy, o_fill_we, o_miss_ack}), 32'd0);
    do_miss(20'h2468a, 8'hff, ORD_UP, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_first", 32'(t_req_first), 32'd1);
    chk("post_rst_ack",   32'(t_ack_cyc), 32'd5);
    chk("post_rst_way",   32'(t_hit_way), 32'h80);

    // Response pulse while idle is ignored; a held miss request is re-accepted right after ack.
    @(negedge clk);
    i_mem_rsp_valid = 1'b1;
    @(negedge clk);
    i_mem_rsp_valid = 1'b0;
    chk("idle_rsp_ignored", 32'({o_busy, o_mem_req_valid}), 32'd0);
    do_miss(20'h11111, 8'hff, ORD_UP, 0, 0, 1'b0, 1'b1, 1'b1);
    chk("hold1_ack_cyc", 32'(t_ack_cyc), 32'd4);
    do_miss(20'h22222, 8'hfe, ORD_DN, 1, 0, 1'b0, 1'b0, 1'b0);
    chk("hold2_busy0",  32'(t_busy0), 32'd0);
    chk("hold2_first",  32'(t_req_first), 32'd1);
    chk("hold2_victim", 32'(o_victim_way), 32'd0);
    chk("hold2_ack",    32'(t_ack_cyc), 32'd5);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/victim_fill_ctrl.md
VICTIM_FILL_CTRL -- requirements
Module: victim_fill_ctrl

Interface
REQ-001 Parameter TAG_W, default 20, sets the tag width of all tag ports.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports: clk  in  1  clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_miss_req  in  1  miss pending from lookup; held high until o_miss_ack.
REQ-005 i_miss_tag  in  TAG_W  tag of missing line, valid with i_miss_req.
REQ-006 i_way_valid_8  in  8  per-way valid bits.
REQ-007 i_lru_order0..i_lru_order6  in  3 each  LRU stack from LRU buffer_out0..6; entry 0 is MRU, 8th (LRU) way is implied.
REQ-008 o_mem_req_valid  out  1;  i_mem_req_ready  in  1;  o_mem_req_tag  out  TAG_W  refill request channel.
REQ-009 i_mem_rsp_valid  in  1;  i_mem_rsp_err  in  1  refill response, one-cycle pulse.
REQ-010 o_fill_we  out  1;  o_fill_way_8  out  8 one-hot;  o_fill_tag  out  TAG_W  way write strobe.
REQ-011 o_hit_way_8  out  8;  o_hit_sig  out  1;  o_lru_write_enable  out  1  LRU update, drives LRU i_hit_way_8/i_hit_sig/i_lru_write_enable.
REQ-012 o_miss_ack  out  1;  o_miss_err  out  1;  o_busy  out  1;  o_victim_way  out  3.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, FILL, UPDATE, ABORT; all outputs decoded from registered state and latched registers only (no input-to-output combinational path).
REQ-014 IDLE: on i_miss_req=1, latch i_miss_tag and victim, go to REQ next cycle; otherwise stay.
REQ-015 Victim: if any i_way_valid_8 bit is 0, lowest-index invalid way; else XOR of i_lru_order0..6 (the way absent from the stack).
REQ-016 Victim and tag SHALL be sampled only in the accepting IDLE cycle; later input changes ignored until the next acceptance.
REQ-017 REQ: o_mem_req_valid=1, o_mem_req_tag = latched tag, both stable while i_mem_req_ready=0; on valid&&ready go to WAIT.
REQ-018 WAIT: on i_mem_rsp_valid with i_mem_rsp_err=0 go to FILL; with err=1 go to ABORT; else stay (no timeout).
REQ-019 i_mem_rsp_valid in IDLE or REQ SHALL be ignored.
REQ-020 FILL (1 cycle): o_fill_we=1, o_fill_way_8 = onehot(victim), o_fill_tag = latched tag; next UPDATE.
REQ-021 UPDATE (1 cycle): o_lru_write_enable=1, o_hit_sig=1, o_hit_way_8 = onehot(victim), o_miss_ack=1; next IDLE.
REQ-022 ABORT (1 cycle): o_miss_ack=1, o_miss_err=1; no fill, no LRU update; next IDLE.
REQ-023 Outside their states, o_fill_we, o_lru_write_enable, o_hit_sig, o_miss_ack, o_miss_err, o_mem_req_valid = 0 and o_hit_way_8, o_fill_way_8 = 8'h00.
REQ-024 o_busy=1 in every state except IDLE; o_victim_way holds last latched victim.
REQ-025 Latency: accept at cycle 0, request at 1; ready at 1 and response at k>=2 give FILL at k+1, UPDATE/ack at k+2, IDLE at k+3 (minimum 4 cycles accept-to-ack).
REQ-026 i_miss_req still high in the IDLE cycle after ack SHALL be accepted as a new miss.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, all outputs 0, o_victim_way=0, latched tag=0, in any state, dropping an unhandshaken o_mem_req_valid.
REQ-028 After rst deasserts, the first acceptance is possible on the first rising edge with i_miss_req=1.

Verification
REQ-029 All valid, order0..6=0,1,2,3,4,5,6, tag 20'h12345, ready=1, rsp at cycle 3 -> victim 7, o_mem_req_tag=20'h12345 at cycle 1, o_fill_way_8=8'h80 at cycle 4, o_hit_way_8=8'h80 with ack at cycle 5.
REQ-030 All valid, order0..6=7,6,5,4,3,2,1 -> o_victim_way=0, o_fill_way_8=8'h01; i_way_valid_8=8'b11110111 with the same order -> victim 3, 8'h08.
REQ-031 ready held 0 for 5 cycles in REQ, tag input changed meanwhile -> o_mem_req_valid=1 and o_mem_req_tag unchanged all 5 cycles; single handshake.
REQ-032 Response with i_mem_rsp_err=1 -> one cycle o_miss_ack=1, o_miss_err=1; o_fill_we and o_lru_write_enable never assert; IDLE next.
REQ-033 rst pulsed in WAIT -> all outputs 0 asynchronously, later rsp ignored, fresh miss completes normally.
REQ-034 i_mem_rsp_valid pulsed in IDLE and REQ -> no state change; i_miss_req held after ack -> second miss accepted next cycle.
